ddr_burst_sched: RTL

Parametrised DDR5 data-burst scheduler that replaces the fixed-latency command queue feeding the SerDes. It accepts read/write commands through a valid/ready handshake and books each burst into a cycle-accurate slot timeline using runtime-selected CL/CWL and BL8/BL16. It drives the SerDes enable/select with burst framing, rejecting any command whose burst would collide with, or violate read/write turnaround against, already-booked bursts. It sits between the command issue logic and the PHY SerDes.

---
 rtl/ddr_sched_pkg.sv | 21 ++
 rtl/ddr_slot_timeline.sv | 71 +++++++
 rtl/ddr_burst_sched.sv | 76 +++++++
 3 files changed

// File: rtl/ddr_sched_pkg.sv
// Shared types and helpers for the DDR5 data-burst scheduler.
package ddr_sched_pkg;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef struct packed {
    logic v;
    logic rw;
    logic start;
    logic last;
  } slot_t;

  // Zero latency is promoted to one; anything beyond the timeline reach saturates.
  function automatic int clamp_lat(input int lat, input int lat_max);
    if (lat < 1) return 1;
    if (lat > lat_max) return lat_max;
    return lat;
  endfunction

endpackage

// File: rtl/ddr_slot_timeline.sv
// Cycle-accurate slot timeline: shifts one slot per clock, books bursts and
// checks new bursts for collision and read/write turnaround.
module ddr_slot_timeline
  import ddr_sched_pkg::*;
#(
  parameter int D  = 50,
  parameter int TA = 2,
  parameter int LW = 6,
  parameter int BW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mark,
  input  logic          rw,
  input  logic [LW-1:0] lat,
  input  logic [BW-1:0] blen,
  output logic          fits,
  output slot_t         head,
  output logic          any_v
);

  slot_t [D-1:0] slot_q;
  slot_t [D-1:0] slot_d;
  int lo;
  int hi;

  // Pre-shift window of the candidate burst: slots lo..hi.
  always_comb begin
    lo = int'(lat);
    hi = lo + int'(blen) - 1;
  end

  // NOTE: combinational blocks assign a default before any conditional update
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    fits = 1'b1;
    for (int i = 1; i < D; i++) begin
      if (slot_q[i].v) begin
        if (i >= lo && i <= hi) fits = 1'b0;
        if (slot_q[i].rw != rw &&
            ((i >= lo - TA && i < lo) || (i > hi && i <= hi + TA))) fits = 1'b0;
      end
    end
  end

  always_comb begin
    slot_d[D-1] = '0;
    for (int i = 0; i < D - 1; i++) slot_d[i] = slot_q[i+1];
    if (mark) begin
      for (int i = 0; i < D; i++) begin
        if (i >= lo - 1 && i <= hi - 1)
          slot_d[i] = slot_t'{v: 1'b1, rw: rw, start: (i == lo - 1), last: (i == hi - 1)};
      end
    end
  end

  always_comb begin
    any_v = 1'b0;
    for (int i = 0; i < D; i++) any_v = any_v | slot_q[i].v;
  end

  // NOTE: the whole timeline is reset, not just a pointer, because reset must
  // abort bursts already in flight and drop every booking immediately.
  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign head = slot_q[0];

endmodule

// File: rtl/ddr_burst_sched.sv
// DDR5 data-burst scheduler: admits read/write commands into a slot timeline
// and drives the SerDes enable/select with burst framing.
module ddr_burst_sched
  import ddr_sched_pkg::*;
#(
  parameter int LAT_MAX = 32,
  parameter int BL_MAX  = 16,
  parameter int TA      = 2,
  parameter int LAT_W   = $clog2(LAT_MAX + 1),
  parameter int CNT_W   = $clog2((LAT_MAX + BL_MAX + TA) / (BL_MAX / 2) + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_rw,
  output logic             cmd_ready,
  input  logic [LAT_W-1:0] cfg_cl,
  input  logic [LAT_W-1:0] cfg_cwl,
  input  logic             cfg_bl16,
  output logic             serdes_en,
  output logic             serdes_sel,
  output logic             burst_start,
  output logic             burst_last,
  output logic             busy,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int D  = LAT_MAX + BL_MAX + TA;
  localparam int BW = $clog2(BL_MAX + 1);

  logic [LAT_W-1:0] lat_eff;
  logic [BW-1:0]    blen;
  logic             fits;
  logic             accept;
  logic             any_v;
  slot_t            head;

  always_comb begin
    lat_eff = LAT_W'(clamp_lat(int'(cmd_rw == WR ? cfg_cwl : cfg_cl), LAT_MAX));
    blen    = cfg_bl16 ? BW'(BL_MAX) : BW'(BL_MAX / 2);
  end

  assign cmd_ready = !rst && fits;
  assign accept    = cmd_valid && cmd_ready;

  ddr_slot_timeline #(
    .D  (D),
    .TA (TA),
    .LW (LAT_W),
    .BW (BW)
  ) u_timeline (
    .clk   (clk),
    .rst   (rst),
    .mark  (accept),
    .rw    (cmd_rw),
    .lat   (lat_eff),
    .blen  (blen),
    .fits  (fits),
    .head  (head),
    .any_v (any_v)
  );

  // Accept and burst completion in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst)                       out_cnt <= '0;
    else if (accept && !head.last) out_cnt <= out_cnt + CNT_W'(1);
    else if (!accept && head.last) out_cnt <= out_cnt - CNT_W'(1);
  end

  assign serdes_en   = head.v;
  assign serdes_sel  = head.rw;
  assign burst_start = head.start;
  assign burst_last  = head.last;
  assign busy        = any_v;

endmodule
